// File: rtl/serdes_rx_word_aligner.sv
// serdes_rx_word_aligner: finds the word boundary of one SerDes RX lane and emits aligned words.
// Latency: one rxclk; the word built from raw cycles N-1 and N is on rx_data after edge N.
// Backpressure: none; one raw word is consumed every rxclk, rx_valid marks aligned output.
module serdes_rx_word_aligner #(
  parameter int DATA_WIDTH = 8,
  // Default is {55..55, BC}: an all-0x55 word with the low byte flipped to 0xBC.
  parameter logic [DATA_WIDTH-1:0] SYNC_PATTERN =
    {(DATA_WIDTH/8){8'h55}} ^ DATA_WIDTH'(8'hE9),
  parameter int LOCK_COUNT   = 4,
  parameter int LOSS_TIMEOUT = 16,
  localparam int OW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1
) (
  input  logic                  rxclk,
  input  logic                  rx_reset,
  input  logic                  enable,
  input  logic                  rx_align,
  input  logic [DATA_WIDTH-1:0] rx_data_raw,
  output logic [DATA_WIDTH-1:0] rx_data,
  output logic                  rx_locked,
  output logic                  rx_valid,
  output logic [OW-1:0]         rx_offset,
  output logic                  rx_lock_lost
);

  localparam int CW = $clog2(LOCK_COUNT + 1);
  localparam int GW = $clog2(LOSS_TIMEOUT + 1);

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_SEARCH  = 2'd1;
  localparam logic [1:0] ST_CONFIRM = 2'd2;
  localparam logic [1:0] ST_LOCKED  = 2'd3;

  logic [1:0]              state;
  logic [CW-1:0]           cnt;
  logic [GW-1:0]           gap;
  logic [DATA_WIDTH-1:0]   prev;

  logic [2*DATA_WIDTH-1:0] comp;
  logic [DATA_WIDTH-1:0]   cand [DATA_WIDTH];
  logic [DATA_WIDTH-1:0]   match;
  logic                    any_match;
  logic [OW-1:0]           first_k;
  logic [DATA_WIDTH-1:0]   first_cand;
  logic                    cur_match;
  logic [DATA_WIDTH-1:0]   cur_cand;

  logic [CW-1:0]           cnt_inc;
  logic [GW-1:0]           gap_inc;
  logic                    cnt_done;
  logic                    gap_done;
  logic                    to_idle;

  // Two consecutive raw words hold every possible alignment of one word.
  assign comp = {rx_data_raw, prev};

  for (genvar k = 0; k < DATA_WIDTH; k++) begin : g_cand
    assign cand[k]  = comp[k +: DATA_WIDTH];
    assign match[k] = (cand[k] == SYNC_PATTERN);
  end

  assign any_match = |match;

  // Lowest matching offset wins; scanning high to low leaves the lowest hit last.
  always_comb begin
    first_k = '0;
    for (int k = DATA_WIDTH - 1; k >= 0; k--) begin
      if (match[k]) first_k = OW'(k);
    end
  end

  assign first_cand = cand[first_k];
  assign cur_cand   = cand[rx_offset];
  assign cur_match  = match[rx_offset];

  // Counters saturate at their limits so they can never wrap back to a small value.
  assign cnt_inc  = (cnt == CW'(LOCK_COUNT))   ? cnt : cnt + CW'(1);
  assign gap_inc  = (gap == GW'(LOSS_TIMEOUT)) ? gap : gap + GW'(1);
  assign cnt_done = (cnt_inc == CW'(LOCK_COUNT));
  assign gap_done = (gap_inc == GW'(LOSS_TIMEOUT));

  // Reset beats enable beats rx_align; rx_align only matters while acquiring lock.
  assign to_idle = rx_reset || !enable ||
                   (!rx_align && (state == ST_SEARCH || state == ST_CONFIRM));

  assign rx_valid = rx_locked;

  // Previous raw word, needed to assemble the straddling candidates.
  always_ff @(posedge rxclk) begin
    if (rx_reset) prev <= '0;
    else          prev <= rx_data_raw;
  end

  // Acquisition / tracking state machine; all outputs are registered here.
  always_ff @(posedge rxclk) begin
    if (to_idle) begin
      state        <= ST_IDLE;
      cnt          <= '0;
      gap          <= '0;
      rx_offset    <= '0;
      rx_data      <= '0;
      rx_locked    <= 1'b0;
      rx_lock_lost <= 1'b0;
    end else begin
      rx_lock_lost <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (rx_align) state <= ST_SEARCH;
        end

        ST_SEARCH: begin
          if (any_match) begin
            rx_offset <= first_k;
            cnt       <= CW'(1);
            gap       <= '0;
            // A single required match means the first hit is already a lock.
            if (LOCK_COUNT == 1) begin
              state     <= ST_LOCKED;
              rx_locked <= 1'b1;
              rx_data   <= first_cand;
            end else begin
              state <= ST_CONFIRM;
            end
          end
        end

        ST_CONFIRM: begin
          if (cur_match) begin
            cnt <= cnt_inc;
            gap <= '0;
            if (cnt_done) begin
              state     <= ST_LOCKED;
              rx_locked <= 1'b1;
              rx_data   <= cur_cand;
            end
          end else if (any_match) begin
            // The boundary moved before we confirmed it: restart on the new offset.
            rx_offset <= first_k;
            cnt       <= CW'(1);
            gap       <= '0;
          end else if (gap_done) begin
            state <= ST_SEARCH;
            cnt   <= '0;
            gap   <= '0;
          end else begin
            gap <= gap_inc;
          end
        end

        ST_LOCKED: begin
          if (cur_match) begin
            gap     <= '0;
            rx_data <= cur_cand;
          end else if (gap_done) begin
            // Too long without a sync word: drop lock and hunt again.
            state        <= ST_SEARCH;
            cnt          <= '0;
            gap          <= '0;
            rx_locked    <= 1'b0;
            rx_data      <= '0;
            rx_lock_lost <= 1'b1;
          end else begin
            gap     <= gap_inc;
            rx_data <= cur_cand;
          end
        end

        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_serdes_rx_word_aligner.sv
// tb_serdes_rx_word_aligner: directed and random stimulus against a behavioural lane model.
// Two aligners share the inputs: sync 0xBC and sync 0xAA.
// Outputs are sampled 1 time unit after each rising rxclk edge.
module tb_serdes_rx_word_aligner;

  localparam int LC = 4;
  localparam int LT = 16;

  localparam int M_IDLE    = 0;
  localparam int M_SEARCH  = 1;
  localparam int M_CONFIRM = 2;
  localparam int M_LOCKED  = 3;

  logic       rxclk;
  logic       rx_reset;
  logic       enable;
  logic       rx_align;
  logic [7:0] rx_data_raw;

  logic [7:0] o_data   [2];
  logic       o_locked [2];
  logic       o_valid  [2];
  logic [2:0] o_off    [2];
  logic       o_lost   [2];

  int checks   = 0;
  int failures = 0;

  // Behavioural lane model (one per instance); raw history is shared.
  int sync_v   [2] = '{8'hBC, 8'hAA};
  int m_state  [2];
  int m_cnt    [2];
  int m_gap    [2];
  int m_off    [2];
  int m_data   [2];
  int m_locked [2];
  int m_lost   [2];
  int m_prev;

  serdes_rx_word_aligner #(
    .DATA_WIDTH(8), .SYNC_PATTERN(8'hBC), .LOCK_COUNT(LC), .LOSS_TIMEOUT(LT)
  ) dut_bc (
    .rxclk(rxclk), .rx_reset(rx_reset), .enable(enable), .rx_align(rx_align),
    .rx_data_raw(rx_data_raw), .rx_data(o_data[0]), .rx_locked(o_locked[0]),
    .rx_valid(o_valid[0]), .rx_offset(o_off[0]), .rx_lock_lost(o_lost[0])
  );

  serdes_rx_word_aligner #(
    .DATA_WIDTH(8), .SYNC_PATTERN(8'hAA), .LOCK_COUNT(LC), .LOSS_TIMEOUT(LT)
  ) dut_aa (
    .rxclk(rxclk), .rx_reset(rx_reset), .enable(enable), .rx_align(rx_align),
    .rx_data_raw(rx_data_raw), .rx_data(o_data[1]), .rx_locked(o_locked[1]),
    .rx_valid(o_valid[1]), .rx_offset(o_off[1]), .rx_lock_lost(o_lost[1])
  );

  initial begin
    rxclk = 1'b0;
    forever #5 rxclk = ~rxclk;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Raw word for a serial stream repeating pattern p, aligned at offset ph.
  function automatic logic [7:0] phase_word(input logic [7:0] p, input int ph);
    logic [15:0] d;
    d = {p, p} << ph;
    return d[15:8];
  endfunction

  task automatic model_idle(input int i);
    m_state[i]  = M_IDLE;
    m_cnt[i]    = 0;
    m_gap[i]    = 0;
    m_off[i]    = 0;
    m_data[i]   = 0;
    m_locked[i] = 0;
  endtask

  // Apply one rxclk edge of the lane rules to the model.
  task automatic model_edge(input logic [7:0] raw, input bit en, input bit al, input bit rst);
    for (int i = 0; i < 2; i++) begin
      int  comp;
      int  low;
      bit  hit;
      comp = (int'(raw) << 8) | m_prev;
      low  = -1;
      for (int k = 7; k >= 0; k--)
        if (((comp >> k) & 255) == sync_v[i]) low = k;
      hit = (((comp >> m_off[i]) & 255) == sync_v[i]);
      m_lost[i] = 0;
      if (rst || !en) begin
        model_idle(i);
      end else if (!al && (m_state[i] == M_SEARCH || m_state[i] == M_CONFIRM)) begin
        model_idle(i);
      end else if (m_state[i] == M_IDLE) begin
        if (al) m_state[i] = M_SEARCH;
      end else if (m_state[i] == M_SEARCH) begin
        if (low >= 0) begin
          m_off[i] = low;
          m_cnt[i] = 1;
          m_gap[i] = 0;
          if (m_cnt[i] >= LC) begin
            m_state[i]  = M_LOCKED;
            m_locked[i] = 1;
            m_data[i]   = (comp >> low) & 255;
          end else begin
            m_state[i] = M_CONFIRM;
          end
        end
      end else if (m_state[i] == M_CONFIRM) begin
        if (hit) begin
          m_cnt[i]++;
          m_gap[i] = 0;
          if (m_cnt[i] >= LC) begin
            m_state[i]  = M_LOCKED;
            m_locked[i] = 1;
            m_data[i]   = (comp >> m_off[i]) & 255;
          end
        end else if (low >= 0) begin
          m_off[i] = low;
          m_cnt[i] = 1;
          m_gap[i] = 0;
        end else begin
          m_gap[i]++;
          if (m_gap[i] >= LT) begin
            m_state[i] = M_SEARCH;
            m_cnt[i]   = 0;
            m_gap[i]   = 0;
          end
        end
      end else begin
        if (hit) begin
          m_gap[i]  = 0;
          m_data[i] = (comp >> m_off[i]) & 255;
        end else begin
          m_gap[i]++;
          if (m_gap[i] >= LT) begin
            m_state[i]  = M_SEARCH;
            m_cnt[i]    = 0;
            m_gap[i]    = 0;
            m_locked[i] = 0;
            m_data[i]   = 0;
            m_lost[i]   = 1;
          end else begin
            m_data[i] = (comp >> m_off[i]) & 255;
          end
        end
      end
    end
    m_prev = rst ? 0 : int'(raw);
  endtask

  task automatic compare_all();
    for (int i = 0; i < 2; i++) begin
      chk($sformatf("data%0d", i),   o_data[i],   m_data[i]);
      chk($sformatf("locked%0d", i), o_locked[i], m_locked[i]);
      chk($sformatf("valid%0d", i),  o_valid[i],  m_locked[i]);
      chk($sformatf("offset%0d", i), o_off[i],    m_off[i]);
      chk($sformatf("lost%0d", i),   o_lost[i],   m_lost[i]);
    end
  endtask

  // Drive one word, clock it, advance the model, then compare every output.
  task automatic step(input logic [7:0] raw, input bit en, input bit al, input bit rst);
    rx_data_raw = raw;
    enable      = en;
    rx_align    = al;
    rx_reset    = rst;
    @(posedge rxclk);
    model_edge(raw, en, al, rst);
    #1;
    compare_all();
  endtask

  logic [7:0] w3, w5, w6, w;
  int         lost_n;
  int         ph;

  initial begin
    w3 = phase_word(8'hBC, 3);
    w5 = phase_word(8'hBC, 5);
    w6 = phase_word(8'hBC, 6);
    for (int i = 0; i < 2; i++) begin
      model_idle(i);
      m_lost[i] = 0;
    end
    m_prev      = 0;
    rx_reset    = 1'b1;
    enable      = 1'b0;
    rx_align    = 1'b0;
    rx_data_raw = 8'h00;

    // Reset with random data, then release with rx_align low.
    for (int n = 0; n < 3; n++) begin
      step(8'($urandom), 1'b1, 1'b1, 1'b1);
      chk("rst_locked", o_locked[0], 1'b0);
      chk("rst_data", o_data[0], 8'h00);
    end
    for (int n = 0; n < 4; n++) begin
      step(w3, 1'b1, 1'b0, 1'b0);
      chk("noalign_locked", o_locked[0], 1'b0);
    end

    // Lock at offset 3: rx_locked rises on the 5th enabled edge.
    for (int e = 1; e <= 8; e++) begin
      step(w3, 1'b1, 1'b1, 1'b0);
      if (e == 4) chk("lock3_early", o_locked[0], 1'b0);
      if (e == 5) begin
        chk("lock3_rise", o_locked[0], 1'b1);
        chk("lock3_off", o_off[0], 3'd3);
      end
      if (e >= 5) chk("lock3_data", o_data[0], 8'hBC);
    end

    // Phase slip by 2 bits: one lock_lost pulse, relock at offset 5.
    lost_n = 0;
    for (int n = 0; n < 40; n++) begin
      step(w5, 1'b1, 1'b1, 1'b0);
      if (o_lost[0] === 1'b1) lost_n++;
      if (n == 14) chk("slip_still_locked", o_locked[0], 1'b1);
      if (n == 15) chk("slip_lost_pulse", o_lost[0], 1'b1);
    end
    chk("slip_lost_count", lost_n, 1);
    chk("slip_relock", o_locked[0], 1'b1);
    chk("slip_off", o_off[0], 3'd5);

    // Confirm restart: two offset-3 hits, then offset-6 only.
    step(w3, 1'b0, 1'b1, 1'b0);
    for (int e = 1; e <= 3; e++) step(w3, 1'b1, 1'b1, 1'b0);
    for (int e = 4; e <= 9; e++) begin
      step(w6, 1'b1, 1'b1, 1'b0);
      if (e == 5) chk("restart_off", o_off[0], 3'd6);
      if (e == 7) chk("restart_not_yet", o_locked[0], 1'b0);
      if (e == 8) chk("restart_lock", o_locked[0], 1'b1);
    end

    // Priority: 0x55 stream against sync 0xAA matches offsets 1,3,5,7.
    step(8'h55, 1'b0, 1'b1, 1'b0);
    for (int e = 1; e <= 6; e++) begin
      step(8'h55, 1'b1, 1'b1, 1'b0);
      if (e == 2) chk("prio_off_confirm", o_off[1], 3'd1);
    end
    chk("prio_locked", o_locked[1], 1'b1);
    chk("prio_off", o_off[1], 3'd1);
    chk("prio_data", o_data[1], 8'hAA);

    // Mid-lock enable drop, mid-lock reset, and rx_align drop while locked.
    step(w3, 1'b0, 1'b1, 1'b0);
    for (int e = 1; e <= 6; e++) step(w3, 1'b1, 1'b1, 1'b0);
    chk("pre_drop_locked", o_locked[0], 1'b1);
    step(w3, 1'b0, 1'b1, 1'b0);
    chk("en_drop_locked", o_locked[0], 1'b0);
    chk("en_drop_data", o_data[0], 8'h00);
    chk("en_drop_lost", o_lost[0], 1'b0);
    for (int e = 1; e <= 6; e++) step(w3, 1'b1, 1'b1, 1'b0);
    chk("pre_rst_locked", o_locked[0], 1'b1);
    step(w3, 1'b1, 1'b1, 1'b1);
    chk("rst_drop_locked", o_locked[0], 1'b0);
    chk("rst_drop_data", o_data[0], 8'h00);
    chk("rst_drop_lost", o_lost[0], 1'b0);
    for (int e = 1; e <= 6; e++) step(w3, 1'b1, 1'b1, 1'b0);
    for (int e = 1; e <= 10; e++) step(w3, 1'b1, 1'b0, 1'b0);
    chk("align_drop_held", o_locked[0], 1'b1);
    chk("align_drop_data", o_data[0], 8'hBC);

    // Timeout inside CONFIRM: one hit, then zeros until the search restarts.
    step(w3, 1'b0, 1'b1, 1'b0);
    step(w3, 1'b1, 1'b1, 1'b0);
    step(w3, 1'b1, 1'b1, 1'b0);
    for (int e = 0; e < 20; e++) step(8'h00, 1'b1, 1'b1, 1'b0);
    chk("confirm_timeout_locked", o_locked[0], 1'b0);

    // Random mixture of streams, slips, noise and control changes.
    ph = 3;
    for (int n = 0; n < 600; n++) begin
      if ($urandom_range(0, 99) < 3) ph = $urandom_range(0, 7);
      case ($urandom_range(0, 9))
        0:       w = 8'($urandom);
        1:       w = phase_word(8'hAA, ph);
        default: w = phase_word(8'hBC, ph);
      endcase
      step(w, $urandom_range(0, 99) >= 3, $urandom_range(0, 99) >= 8,
           $urandom_range(0, 299) == 0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
